// File: rtl/xpushs_bank.sv
// Push-button front end: synchronise, debounce, capture press events.
// Sticky pending register with overflow flag; optional auto-repeat.
module xpushs_bank #(
    parameter int N_BTN       = 4,
    parameter int DB_CYCLES   = 16,
    parameter int REPEAT_EN   = 0,
    parameter int REPEAT_DLY  = 256,
    parameter int REPEAT_RATE = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] push_in,
    input  logic             sel,
    output logic [N_BTN-1:0] level_out,
    output logic [N_BTN-1:0] event_out,
    output logic             event_vld,
    output logic             overflow
);

    localparam int DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

    // repeat hardware only exists for a sane, enabled configuration
    localparam int RPT_ON =
        (REPEAT_EN != 0 && REPEAT_DLY >= 2 && REPEAT_RATE >= 2) ? 1 : 0;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_level_d;
    logic [DB_W-1:0]  r_db_cnt [N_BTN];
    logic [N_BTN-1:0] r_pend;
    logic             r_vld;
    logic             r_ovf;

    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_rpt;
    logic [N_BTN-1:0] w_new;
    logic [N_BTN-1:0] w_pend_nxt;
    logic             w_ovf_set;

    // two-flop synchroniser on the raw asynchronous buttons
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= push_in;
            r_sync2 <= r_sync1;
        end
    end

    // per-channel debounce: level flips only after a long enough clean hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_MAX) begin
                    r_level[i]  <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // delayed level for press (rising edge) detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level_d <= '0;
        end else begin
            r_level_d <= r_level;
        end
    end

    assign w_rise = r_level & ~r_level_d;

    generate
        if (RPT_ON != 0) begin : g_rpt
            localparam int RP_MAX =
                (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
            localparam int RP_W = $clog2(RP_MAX + 1);
            localparam logic [RP_W-1:0] DLY_V  = RP_W'(REPEAT_DLY);
            localparam logic [RP_W-1:0] RATE_V = RP_W'(REPEAT_RATE);

            logic [RP_W-1:0]  r_rpt_cnt [N_BTN];
            logic [N_BTN-1:0] r_rpt_ph;
            logic [N_BTN-1:0] w_hit;

            // repeat fires at DLY after the press, then every RATE
            always_comb begin
                w_hit = '0;
                for (int i = 0; i < N_BTN; i++) begin
                    if (r_rpt_ph[i]) begin
                        w_hit[i] = r_level[i] && (r_rpt_cnt[i] == RATE_V);
                    end else begin
                        w_hit[i] = r_level[i] && (r_rpt_cnt[i] == DLY_V);
                    end
                end
            end

            // cycle counter runs while held, cleared while released
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_rpt_ph <= '0;
                    for (int i = 0; i < N_BTN; i++) begin
                        r_rpt_cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < N_BTN; i++) begin
                        if (!r_level[i]) begin
                            r_rpt_cnt[i] <= '0;
                            r_rpt_ph[i]  <= 1'b0;
                        end else if (w_hit[i]) begin
                            r_rpt_cnt[i] <= RP_W'(1);
                            r_rpt_ph[i]  <= 1'b1;
                        end else begin
                            r_rpt_cnt[i] <= r_rpt_cnt[i] + 1'b1;
                        end
                    end
                end
            end

            assign w_rpt = w_hit;
        end else begin : g_norpt
            assign w_rpt = '0;
        end
    endgenerate

    assign w_new      = w_rise | w_rpt;
    assign w_pend_nxt = sel ? w_new : (r_pend | w_new);
    assign w_ovf_set  = ~sel & (|(w_new & r_pend));

    // sticky pending events, registered valid and overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
            r_vld  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_vld  <= |w_pend_nxt;
            r_ovf  <= w_ovf_set | (r_ovf & ~sel);
        end
    end

    assign level_out = r_level;
    assign event_out = r_pend;
    assign event_vld = r_vld;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_xpushs_bank.sv
// Directed bench for xpushs_bank: debounce timing, events, ack, overflow,
// auto-repeat and asynchronous reset.
module tb_xpushs_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] push_a = '0;
    logic       sel_a = 1'b0;
    logic [3:0] lv_a, ev_a;
    logic       vld_a, ovf_a;
    logic [3:0] push_b = '0;
    logic       sel_b = 1'b0;
    logic [3:0] lv_b, ev_b;
    logic       vld_b, ovf_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    xpushs_bank #(
        .N_BTN(4), .DB_CYCLES(4), .REPEAT_EN(0),
        .REPEAT_DLY(8), .REPEAT_RATE(4)
    ) u_dut (
        .clk(clk), .rst(rst), .push_in(push_a), .sel(sel_a),
        .level_out(lv_a), .event_out(ev_a),
        .event_vld(vld_a), .overflow(ovf_a)
    );

    xpushs_bank #(
        .N_BTN(4), .DB_CYCLES(4), .REPEAT_EN(1),
        .REPEAT_DLY(8), .REPEAT_RATE(4)
    ) u_rpt (
        .clk(clk), .rst(rst), .push_in(push_b), .sel(sel_b),
        .level_out(lv_b), .event_out(ev_b),
        .event_vld(vld_b), .overflow(ovf_b)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        #12;
        n_cmp++;
        if ({lv_a, ev_a, vld_a, ovf_a} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_a got=%b exp=0", {lv_a, ev_a, vld_a, ovf_a});
        end
        n_cmp++;
        if ({lv_b, ev_b, vld_b, ovf_b} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_b got=%b exp=0", {lv_b, ev_b, vld_b, ovf_b});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_press;
        push_a = 4'b0001;
        tick(5);
        n_cmp++;
        if (lv_a !== 4'b0000) begin
            n_err++;
            $display("FAIL press_early_level got=%b exp=0000", lv_a);
        end
        tick(1);
        n_cmp++;
        if (lv_a !== 4'b0001 || ev_a !== 4'b0000) begin
            n_err++;
            $display("FAIL press_level got=%b/%b exp=0001/0000", lv_a, ev_a);
        end
        tick(1);
        n_cmp++;
        if (ev_a !== 4'b0001 || vld_a !== 1'b1) begin
            n_err++;
            $display("FAIL press_event got=%b/%b exp=0001/1", ev_a, vld_a);
        end
    endtask

    task automatic test_ack_new;
        push_a = 4'b0101;
        tick(6);
        n_cmp++;
        if (lv_a !== 4'b0101 || ev_a !== 4'b0001) begin
            n_err++;
            $display("FAIL sticky got=%b/%b exp=0101/0001", lv_a, ev_a);
        end
        sel_a = 1'b1;
        tick(1);
        n_cmp++;
        if (ev_a !== 4'b0100 || vld_a !== 1'b1) begin
            n_err++;
            $display("FAIL ack_keep_new got=%b/%b exp=0100/1", ev_a, vld_a);
        end
        tick(1);
        sel_a = 1'b0;
        n_cmp++;
        if (ev_a !== 4'b0000 || vld_a !== 1'b0 || ovf_a !== 1'b0) begin
            n_err++;
            $display("FAIL ack_clear got=%b/%b/%b exp=0000/0/0",
                     ev_a, vld_a, ovf_a);
        end
        push_a = 4'b0000;
        tick(8);
        n_cmp++;
        if (lv_a !== 4'b0000 || ev_a !== 4'b0000) begin
            n_err++;
            $display("FAIL release got=%b/%b exp=0000/0000", lv_a, ev_a);
        end
    endtask

    task automatic test_glitch;
        push_a = 4'b0010;
        tick(3);
        push_a = 4'b0000;
        tick(8);
        n_cmp++;
        if (lv_a !== 4'b0000 || ev_a !== 4'b0000) begin
            n_err++;
            $display("FAIL glitch3 got=%b/%b exp=0000/0000", lv_a, ev_a);
        end
        push_a = 4'b0010;
        tick(4);
        push_a = 4'b0000;
        tick(2);
        n_cmp++;
        if (lv_a !== 4'b0010) begin
            n_err++;
            $display("FAIL pulse4_level got=%b exp=0010", lv_a);
        end
        tick(1);
        n_cmp++;
        if (ev_a !== 4'b0010) begin
            n_err++;
            $display("FAIL pulse4_event got=%b exp=0010", ev_a);
        end
        sel_a = 1'b1;
        tick(1);
        sel_a = 1'b0;
        tick(8);
        n_cmp++;
        if (lv_a !== 4'b0000 || ev_a !== 4'b0000) begin
            n_err++;
            $display("FAIL pulse4_after got=%b/%b exp=0000/0000", lv_a, ev_a);
        end
    endtask

    task automatic test_overflow;
        push_a = 4'b1000;
        tick(7);
        n_cmp++;
        if (ev_a !== 4'b1000 || ovf_a !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_first got=%b/%b exp=1000/0", ev_a, ovf_a);
        end
        push_a = 4'b0000;
        tick(7);
        push_a = 4'b1000;
        tick(6);
        n_cmp++;
        if (ovf_a !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_early got=%b exp=0", ovf_a);
        end
        tick(1);
        n_cmp++;
        if (ovf_a !== 1'b1 || ev_a !== 4'b1000 || vld_a !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set got=%b/%b/%b exp=1/1000/1",
                     ovf_a, ev_a, vld_a);
        end
        tick(3);
        n_cmp++;
        if (ovf_a !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky got=%b exp=1", ovf_a);
        end
        sel_a = 1'b1;
        tick(1);
        sel_a = 1'b0;
        n_cmp++;
        if (ovf_a !== 1'b0 || ev_a !== 4'b0000 || vld_a !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear got=%b/%b/%b exp=0/0000/0",
                     ovf_a, ev_a, vld_a);
        end
        push_a = 4'b0000;
        tick(8);
    endtask

    task automatic test_repeat;
        logic [3:0] exp;
        sel_b  = 1'b1;
        push_b = 4'b0001;
        for (int t = 1; t <= 60; t++) begin
            if (t == 41) push_b = 4'b0000;
            tick(1);
            exp = '0;
            if (t == 7) exp = 4'b0001;
            if (t >= 15 && t <= 43 && ((t - 15) % 4) == 0) exp = 4'b0001;
            n_cmp++;
            if (ev_b !== exp || vld_b !== (|exp)) begin
                n_err++;
                $display("FAIL repeat t=%0d got=%b/%b exp=%b/%b",
                         t, ev_b, vld_b, exp, |exp);
            end
        end
        sel_b = 1'b0;
        n_cmp++;
        if (lv_b !== 4'b0000 || ovf_b !== 1'b0) begin
            n_err++;
            $display("FAIL repeat_end got=%b/%b exp=0000/0", lv_b, ovf_b);
        end
    endtask

    task automatic test_reset_mid;
        push_a = 4'b0010;
        tick(7);
        n_cmp++;
        if (ev_a !== 4'b0010 || lv_a !== 4'b0010) begin
            n_err++;
            $display("FAIL pre_rst got=%b/%b exp=0010/0010", ev_a, lv_a);
        end
        tick(2);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({lv_a, ev_a, vld_a, ovf_a} !== 10'b0) begin
            n_err++;
            $display("FAIL async_rst got=%b exp=0", {lv_a, ev_a, vld_a, ovf_a});
        end
        #2;
        rst = 1'b1;
        tick(5);
        n_cmp++;
        if (lv_a !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_redb_early got=%b exp=0000", lv_a);
        end
        tick(1);
        n_cmp++;
        if (lv_a !== 4'b0010 || ev_a !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_redb got=%b/%b exp=0010/0000", lv_a, ev_a);
        end
        tick(1);
        n_cmp++;
        if (ev_a !== 4'b0010 || vld_a !== 1'b1) begin
            n_err++;
            $display("FAIL rst_event got=%b/%b exp=0010/1", ev_a, vld_a);
        end
    endtask

    initial begin
        test_reset;
        test_press;
        test_ack_new;
        test_glitch;
        test_overflow;
        test_repeat;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
